ir_freq_detector: RTL and testbench
===================================

IR_FREQ_DETECTOR -- requirements
Module: ir_freq_detector

Interface
REQ-001 The block SHALL expose the parameter P1K_MIN, default 90000, the lower bound in clk cycles for a 1 kHz period, inclusive.
REQ-002 The block SHALL expose the parameter P1K_MAX, default 110000, the upper bound in clk cycles for a 1 kHz period, inclusive.
REQ-003 The block SHALL expose the parameter P10K_MIN, default 9000, the lower bound in clk cycles for a 10 kHz period, inclusive.
REQ-004 The block SHALL expose the parameter P10K_MAX, default 11000, the upper bound in clk cycles for a 10 kHz period, inclusive.
REQ-005 The block SHALL expose the parameter LOCK_CNT, default 4, the number of consecutive same-class periods required to assert an output.
REQ-006 The block SHALL have port clk, input, 1 bit: the single 100 MHz system clock.
REQ-007 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port Enable, input, 1 bit: when high, detection runs.
REQ-009 The block SHALL have port IR_Raw, input, 1 bit: asynchronous digital output of the IR receiver comparator.
REQ-010 The block SHALL have port IR_1k, output, 1 bit: a 1 kHz beacon is locked.
REQ-011 The block SHALL have port IR_10k, output, 1 bit: a 10 kHz beacon is locked.
REQ-012 The block SHALL have port Period, output, 17 bits: the last measured period in clk cycles.
REQ-013 The block SHALL have port Valid, output, 1 bit: a one-cycle pulse when Period updates.
REQ-014 The block SHALL use one clock only; Reset SHALL be synchronous and active-high.

Function
REQ-015 IR_Raw SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected from the second flop and a third delay flop, so an edge is flagged 3 cycles after the IR_Raw rise.
REQ-016 The 17-bit counter CNT SHALL load 1 on a detected edge, otherwise increment, saturating at 131071.
REQ-017 The FSM SHALL have two states, NO_SIGNAL and MEASURE.
REQ-018 In NO_SIGNAL, a detected edge SHALL cause transition to MEASURE and load CNT; no Period or Valid SHALL be produced.
REQ-019 In MEASURE, each detected edge SHALL register Period <= CNT (the edge-to-edge distance in cycles) and pulse Valid on the next cycle.
REQ-020 In MEASURE, when CNT reaches 131071 the FSM SHALL go to NO_SIGNAL, clear the match state, and deassert IR_1k/IR_10k on the following cycle.
REQ-021 Each measured period SHALL be classified as C1K (within P1K_MIN..P1K_MAX), C10K (within P10K_MIN..P10K_MAX), or NONE.
REQ-022 The 3-bit match counter SHALL increment, saturating at LOCK_CNT, if the class equals the previous class and is not NONE; otherwise it SHALL be set to 1 for C1K/C10K or 0 for NONE, and the previous class SHALL be updated.
REQ-023 IR_1k SHALL be high when the match counter equals LOCK_CNT with class C1K; IR_10k SHALL follow the same rule for C10K; both SHALL update in the same cycle as Valid.
REQ-024 IR_1k and IR_10k SHALL never be high simultaneously.
REQ-025 A NONE period or a class change SHALL drop the locked output on the same cycle as Valid.
REQ-026 When Enable is low, the block SHALL go to NO_SIGNAL, hold CNT=0, clear the match state and outputs, and hold Period.
REQ-027 An edge coincident with CNT saturation SHALL be treated as an edge: Period=131071 (class NONE) and the block SHALL remain in MEASURE.

Reset
REQ-028 While Reset is high, the block SHALL be in NO_SIGNAL with IR_1k=0, IR_10k=0, Valid=0, Period=0, CNT=0, match counter=0, previous class=NONE, and synchronizer flops=0.
REQ-029 Reset SHALL take priority over Enable and over edges.
REQ-030 Reset mid-lock SHALL deassert the outputs on the first cycle of reset.

Verification
REQ-031 1 kHz square wave (period 100000 cycles), Enable=1: first Valid SHALL occur on the second rise with Period=100000; IR_1k SHALL rise on the 5th IR_Raw rise (4th period); IR_10k SHALL stay 0.
REQ-032 10 kHz square wave (10000 cycles) for 6 rises, then 1 kHz: IR_10k SHALL rise at period 4; the first 1 kHz-class period SHALL drop IR_10k; IR_1k SHALL rise 3 periods later.
REQ-033 Locked at 1 kHz, then IR_Raw held low: IR_1k SHALL fall when CNT saturates (131071 cycles after the last edge); the state SHALL be NO_SIGNAL.
REQ-034 Periods 100000, 100000, 50000, 100000 x4: the 50000 period SHALL give NONE, resetting the match count; IR_1k SHALL assert only after 4 further 100000-cycle periods.
REQ-035 Boundaries: periods of 89999 and 110001 SHALL never lock; periods of 90000 and 110000 SHALL lock IR_1k.
REQ-036 Reset or Enable=0 while locked SHALL clear IR_1k the next cycle; after release, the first edge SHALL produce no Valid.

Source files
------------

// File: rtl/ir_freq_detector.sv
// IR beacon frequency detector.
// IR_Raw is synchronised, and its rising edges are timestamped with a
// saturating cycle counter. Each edge-to-edge period is classified as
// 1 kHz, 10 kHz or neither. An output locks after LOCK_CNT consecutive
// periods of the same class.
// CNT_SAT sets the counter saturation point. It defaults to the full
// 17-bit range and must not exceed 131071.
module ir_freq_detector #(
  parameter int unsigned P1K_MIN  = 90000,
  parameter int unsigned P1K_MAX  = 110000,
  parameter int unsigned P10K_MIN = 9000,
  parameter int unsigned P10K_MAX = 11000,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CNT_SAT  = 131071
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        IR_Raw,
  output logic        IR_1k,
  output logic        IR_10k,
  output logic [16:0] Period,
  output logic        Valid
);

  localparam logic [16:0] P1K_MIN_C  = 17'(P1K_MIN);
  localparam logic [16:0] P1K_MAX_C  = 17'(P1K_MAX);
  localparam logic [16:0] P10K_MIN_C = 17'(P10K_MIN);
  localparam logic [16:0] P10K_MAX_C = 17'(P10K_MAX);
  localparam logic [16:0] SAT_C      = 17'(CNT_SAT);
  localparam logic [2:0]  LOCK_C     = 3'(LOCK_CNT);

  typedef enum logic {
    NO_SIGNAL = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_1K   = 2'd1,
    C_10K  = 2'd2
  } per_class_t;

  logic        sync1_q, sync2_q, sync3_q;
  logic        rise_det;
  logic        cnt_sat;

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic [2:0]  match_q, match_d;
  per_class_t  prev_q, prev_d;
  per_class_t  cls;
  logic        lock1k_q, lock1k_d;
  logic        lock10k_q, lock10k_d;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= IR_Raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_det = sync2_q & ~sync3_q;
  assign cnt_sat  = (cnt_q == SAT_C);

  // Classify the period that an edge arriving this cycle would close.
  always_comb begin
    cls = C_NONE;
    if (cnt_q >= P1K_MIN_C && cnt_q <= P1K_MAX_C) begin
      cls = C_1K;
    end else if (cnt_q >= P10K_MIN_C && cnt_q <= P10K_MAX_C) begin
      cls = C_10K;
    end
  end

  // State, counter, match tracking and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= NO_SIGNAL;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      match_q   <= '0;
      prev_q    <= C_NONE;
      lock1k_q  <= 1'b0;
      lock10k_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      prev_q    <= prev_d;
      lock1k_q  <= lock1k_d;
      lock10k_q <= lock10k_d;
    end
  end

  // Next-state logic: measurement on edges and loss of signal on saturation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    prev_d    = prev_q;
    lock1k_d  = lock1k_q;
    lock10k_d = lock10k_q;

    if (!Enable) begin
      state_d   = NO_SIGNAL;
      cnt_d     = '0;
      match_d   = '0;
      prev_d    = C_NONE;
      lock1k_d  = 1'b0;
      lock10k_d = 1'b0;
    end else begin
      if (rise_det) begin
        cnt_d = 17'd1;
      end else if (!cnt_sat) begin
        cnt_d = cnt_q + 17'd1;
      end

      case (state_q)
        NO_SIGNAL: begin
          if (rise_det) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An edge takes priority over saturation.
          // A period of exactly CNT_SAT is still reported.
          if (rise_det) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            prev_d   = cls;
            if (cls != C_NONE && cls == prev_q) begin
              match_d = (match_q >= LOCK_C) ? LOCK_C : match_q + 3'd1;
            end else if (cls == C_NONE) begin
              match_d = '0;
            end else begin
              match_d = 3'd1;
            end
            lock1k_d  = (cls == C_1K)  && (match_d == LOCK_C);
            lock10k_d = (cls == C_10K) && (match_d == LOCK_C);
          end else if (cnt_sat) begin
            state_d   = NO_SIGNAL;
            match_d   = '0;
            prev_d    = C_NONE;
            lock1k_d  = 1'b0;
            lock10k_d = 1'b0;
          end
        end
        default: state_d = NO_SIGNAL;
      endcase
    end
  end

  assign IR_1k  = lock1k_q;
  assign IR_10k = lock10k_q;
  assign Period = period_q;
  assign Valid  = valid_q;

endmodule

// File: tb/tb_ir_freq_detector.sv
// Bench for ir_freq_detector, using scaled-down periods and saturation.
// A timestamp-based model predicts Valid, Period, IR_1k and IR_10k each cycle.
// Literal checks at key points pin the model's expected behaviour.
module tb_ir_freq_detector;

  localparam int unsigned P1K_MIN  = 540;
  localparam int unsigned P1K_MAX  = 660;
  localparam int unsigned P10K_MIN = 54;
  localparam int unsigned P10K_MAX = 66;
  localparam int unsigned LOCK     = 4;
  localparam int unsigned SAT      = 1800;
  localparam int unsigned LAT      = 3;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        IR_Raw;
  logic        IR_1k;
  logic        IR_10k;
  logic [16:0] Period;
  logic        Valid;

  int checks = 0;
  int errors = 0;

  ir_freq_detector #(
    .P1K_MIN (P1K_MIN),
    .P1K_MAX (P1K_MAX),
    .P10K_MIN(P10K_MIN),
    .P10K_MAX(P10K_MAX),
    .LOCK_CNT(LOCK),
    .CNT_SAT (SAT)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .Enable(Enable),
    .IR_Raw(IR_Raw),
    .IR_1k (IR_1k),
    .IR_10k(IR_10k),
    .Period(Period),
    .Valid (Valid)
  );

  always #5 clk = ~clk;

  // Model state: timestamps of driven rises and a history of period classes.
  int unsigned cyc = 0;
  int unsigned rise_q[$];
  int          hist[$];
  bit          armed = 0;
  bit          meas = 0;
  int unsigned last_e = 0;
  int unsigned m_period = 0;
  bit          m_valid = 0, m_1k = 0, m_10k = 0;

  function automatic int cls_of(input int unsigned p);
    if (p >= P1K_MIN && p <= P1K_MAX) return 1;
    if (p >= P10K_MIN && p <= P10K_MAX) return 2;
    return 0;
  endfunction

  // Locked class: the last LOCK entries are identical and are not NONE.
  function automatic int locked_class();
    int n;
    n = hist.size();
    if (n < int'(LOCK)) return 0;
    for (int k = 1; k < int'(LOCK); k++)
      if (hist[n-1-k] != hist[n-1]) return 0;
    return hist[n-1];
  endfunction

  always @(posedge clk) begin
    bit e;
    int unsigned gap;
    int lk;
    cyc++;
    e = (rise_q.size() > 0) && (rise_q[0] + LAT == cyc);
    if (e) void'(rise_q.pop_front());
    m_valid = 0;
    if (Reset) begin
      armed = 1; meas = 0; hist.delete(); rise_q.delete();
      m_period = 0; m_1k = 0; m_10k = 0;
    end else if (!Enable) begin
      meas = 0; hist.delete(); m_1k = 0; m_10k = 0;
    end else if (e) begin
      if (meas) begin
        gap = cyc - last_e;
        m_period = gap;
        m_valid = 1;
        hist.push_back(cls_of(gap));
        lk = locked_class();
        m_1k = (lk == 1);
        m_10k = (lk == 2);
      end
      meas = 1;
      last_e = cyc;
    end else if (meas && (cyc - last_e) >= SAT) begin
      meas = 0; hist.delete(); m_1k = 0; m_10k = 0;
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Compare the DUT against the model on every falling edge after reset.
  always @(negedge clk) begin
    if (armed) begin
      chk("valid",  32'(Valid),  32'(m_valid));
      chk("period", 32'(Period), m_period);
      chk("ir_1k",  32'(IR_1k),  32'(m_1k));
      chk("ir_10k", 32'(IR_10k), 32'(m_10k));
      chk("excl",   32'(IR_1k & IR_10k), 0);
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One IR period: the rise now, then low halfway through; returns p cycles later.
  task automatic pulse(input int unsigned p);
    IR_Raw = 1'b1;
    rise_q.push_back(cyc);
    wait_cyc(p / 2);
    IR_Raw = 1'b0;
    wait_cyc(p - p / 2);
  endtask

  task automatic toggle_enable();
    Enable = 1'b0;
    wait_cyc(3);
    Enable = 1'b1;
    wait_cyc(2);
  endtask

  int unsigned bvals[8] = '{539, 661, 540, 660, 53, 67, 54, 66};
  bit          b1k[8]   = '{0, 0, 1, 1, 0, 0, 0, 0};
  bit          b10k[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    Reset = 1'b1; Enable = 1'b1; IR_Raw = 1'b0;
    wait_cyc(5);
    chk("rst_period", 32'(Period), 0);
    chk("rst_valid",  32'(Valid),  0);
    chk("rst_1k",     32'(IR_1k),  0);
    Reset = 1'b0;
    wait_cyc(3);

    // 1 kHz square wave: lock on the 5th rise.
    pulse(600); chk("a_r1_period", 32'(Period), 0);
    pulse(600); chk("a_r2_period", 32'(Period), 600);
    pulse(600);
    pulse(600); chk("a_r4_1k", 32'(IR_1k), 0);
    pulse(600); chk("a_r5_1k", 32'(IR_1k), 1); chk("a_r5_10k", 32'(IR_10k), 0);
    pulse(600);
    // Hold low: the lock is lost SAT cycles after the last registered edge.
    wait_cyc(SAT - 600);  chk("a_hold_1k", 32'(IR_1k), 1);
    wait_cyc(4);          chk("a_lost_1k", 32'(IR_1k), 0);
    chk("a_lost_period", 32'(Period), 600);

    // 10 kHz for six rises, then 1 kHz.
    for (int i = 1; i <= 5; i++) begin
      pulse(60);
      if (i == 4) chk("b_r4_10k", 32'(IR_10k), 0);
    end
    chk("b_r5_10k", 32'(IR_10k), 1);
    pulse(600); chk("b_r6_10k", 32'(IR_10k), 1);
    pulse(600); chk("b_r7_10k", 32'(IR_10k), 0); chk("b_r7_1k", 32'(IR_1k), 0);
    pulse(600);
    pulse(600); chk("b_r9_1k", 32'(IR_1k), 0);
    pulse(600); chk("b_r10_1k", 32'(IR_1k), 1);
    // Disabling while locked clears the lock and holds Period.
    Enable = 1'b0;
    wait_cyc(1);
    chk("b_dis_1k", 32'(IR_1k), 0);
    chk("b_dis_period", 32'(Period), 600);
    wait_cyc(4);
    Enable = 1'b1;
    wait_cyc(2);

    // A NONE period (300) in the middle restarts the match count.
    pulse(600); pulse(600); pulse(300);
    pulse(600); chk("c_none_period", 32'(Period), 300); chk("c_none_1k", 32'(IR_1k), 0);
    pulse(600); pulse(600);
    pulse(600); chk("c_r6_1k", 32'(IR_1k), 0);
    pulse(600); chk("c_r7_1k", 32'(IR_1k), 1);
    // Reset while locked.
    Reset = 1'b1;
    wait_cyc(1);
    chk("c_rst_1k", 32'(IR_1k), 0);
    chk("c_rst_period", 32'(Period), 0);
    wait_cyc(3);
    Reset = 1'b0;
    wait_cyc(2);

    // Boundary periods of each class, starting from idle each time.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 6; k++) pulse(bvals[i]);
      chk("d_bound_period", 32'(Period), bvals[i]);
      chk("d_bound_1k",     32'(IR_1k),  32'(b1k[i]));
      chk("d_bound_10k",    32'(IR_10k), 32'(b10k[i]));
      toggle_enable();
    end

    // An edge exactly at saturation is measured; one cycle later is lost.
    pulse(SAT);
    pulse(SAT);     chk("e_sat_period1", 32'(Period), SAT);
    pulse(600);     chk("e_sat_period2", 32'(Period), SAT);
    pulse(SAT + 1); chk("e_pre_loss",    32'(Period), 600);
    pulse(700);     chk("e_after_loss",  32'(Period), 600);
    pulse(700);     chk("e_remeasure",   32'(Period), 700);
    wait_cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
